mux8_bus_arbiter: RTL
=====================

Name: mux8_bus_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the 32-bit 8:1 result mux between eight requesters.
- Drives the mux select, holds the select stable for a granted burst, and registers the mux output into a valid/ready output stage.
- Sits between the eight source units and the single downstream consumer of the muxed 32-bit bus.

Parameters:
- WIDTH, 32, data width of mux_result/out_data.
- MAX_BURST, 4, maximum beats per grant before forced rotation (legal 1..16).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  8  per-requester request; held high until its beat is acked.
- req_last  input  8  per-requester "this beat is final of burst"; sampled only for the granted requester.
- mux_result  input  WIDTH  Result output of the external 8:1 mux.
- sel  output  3  select to the external mux (S); encoded index of the granted requester.
- gnt  output  8  one-hot grant, registered.
- ack  output  8  one-hot, one-cycle pulse: the granted requester's beat was captured this cycle.
- out_data  output  WIDTH  registered captured beat.
- out_valid  output  1  out_data holds an unconsumed beat.
- out_ready  input  1  consumer accepts out_data when out_valid and out_ready are both high.
- busy  output  1  high while in XFER.

Behaviour:
- Reset (async, reset_n=0):
  - State to IDLE.
  - gnt=0, sel=0, ack=0, out_valid=0, out_data=0, busy=0, beat_cnt=0.
  - last_ptr=7, so requester 0 wins first.
- States: IDLE, XFER.
- IDLE:
  - gnt=0, busy=0.
  - If |req: the winner is the first asserted req index scanning last_ptr+1, last_ptr+2, … mod 8.
  - Register gnt/sel to the winner, beat_cnt=0, go XFER.
- XFER:
  - gnt/sel constant.
  - can_cap = !out_valid | out_ready.
  - If req[w] && can_cap:
    - out_data<=mux_result, out_valid<=1.
    - ack[w]=1 (combinational, this cycle).
    - beat_cnt++.
  - Burst end on a capture cycle when req_last[w]=1 or beat_cnt+1==MAX_BURST.
    - On burst end: last_ptr<=w.
    - If another requester (excluding w) is requesting, re-arbitrate from w+1 in the same edge and stay in XFER with the new grant. This gives back-to-back grants with no idle cycle.
    - Else go IDLE.
  - Otherwise (no burst end) stay XFER with the same w.
  - If req[w]=0 (requester withdrew) with no capture: abandon, last_ptr<=w, go IDLE. No ack, no capture.
  - If !can_cap (stall): no capture, no ack, beat_cnt unchanged, sel held.
- Output stage:
  - out_valid clears on out_valid&&out_ready when there is no simultaneous capture.
  - Simultaneous accept and capture: out_valid stays 1 and out_data takes the new beat. Full throughput of 1 beat/cycle.
- Latency: req rises in cycle 0 (IDLE) → gnt/sel valid in cycle 1 → ack in cycle 1 → out_valid in cycle 2.
- Fairness: with all 8 requesting single-beat, grants rotate 0,1,…,7,0. No requester waits more than 7 bursts.
- A requester that keeps req high after its final beat re-enters arbitration at lowest priority.
- gnt is always one-hot or zero. sel==index of gnt when gnt!=0; sel holds its last value in IDLE.
- Asynchronous reset mid-burst:
  - All outputs clear immediately.
  - A beat captured into out_data but not yet accepted is discarded.
  - Requesters must re-request after reset.

Test Plan:
- Single request: req=8'h04 with req_last[2]=1, mux_result=32'hDEADBEEF, out_ready=1 → cycle 1: gnt=8'h04, sel=2, ack=8'h04; cycle 2: out_valid=1, out_data=32'hDEADBEEF; then IDLE, gnt=0.
- Round-robin: req=8'hFF held, all req_last=1, out_ready=1 → sel sequence 0,1,2,…,7,0 on consecutive cycles, one ack per cycle, no idle gap.
- Burst cap, MAX_BURST=4, req_last=0:
  - req=8'h03: requester 0 gets exactly 4 consecutive acks, then sel=1 for 4 acks, then back to 0.
  - req=8'h01 only: requester 0 is re-granted after IDLE.
- Backpressure: out_ready=0 after the first beat → out_valid=1, ack stays 0, sel held, out_data unchanged. Raise out_ready → next beat captured the same cycle it is accepted.
- Withdrawal: req[5] dropped while granted and stalled → no ack[5], next state IDLE, next winner search starts at 6.
- Reset mid-burst: reset_n=0 during beat 2 of a 4-beat burst → gnt=0, out_valid=0, busy=0 immediately. After release, req=8'h80|8'h01 → requester 0 wins first.

Source files
------------

// File: rtl/mux8_bus_arbiter.sv
// Round-robin arbiter/sequencer sharing one 8:1 result mux between eight requesters, with burst hold.
// Latency: req in IDLE -> gnt/sel/ack next cycle -> out_valid the cycle after; back-to-back bursts without a gap.
// Backpressure: out_valid && !out_ready stalls capture (no ack, sel held); accept and capture may share a cycle.
module mux8_bus_arbiter #(
   parameter int WIDTH     = 32,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [7:0]       req,
   input  logic [7:0]       req_last,
   input  logic [WIDTH-1:0] mux_result,
   output logic [2:0]       sel,
   output logic [7:0]       gnt,
   output logic [7:0]       ack,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   state_t     state, state_nxt;
   logic [7:0] gnt_nxt;
   logic [2:0] sel_nxt;
   logic [2:0] last_ptr, last_ptr_nxt;
   logic [4:0] beat_cnt, beat_cnt_nxt;
   logic       can_cap;
   logic       cap;
   logic       burst_end;
   logic [3:0] pick_idle;
   logic [3:0] pick_rearb;

   // {found, index}: first set bit of mask scanning base+1, base+2, ... wrapping back to base.
   function automatic logic [3:0] rr_pick(input logic [7:0] mask, input logic [2:0] base);
      logic       found;
      logic [2:0] idx;
      logic [2:0] cand;
      found = 1'b0;
      idx   = 3'd0;
      for (int i = 1; i <= 8; i++) begin
         cand = base + 3'(i);
         if (!found && mask[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      return {found, idx};
   endfunction

   always_comb begin
      state_nxt    = state;
      gnt_nxt      = gnt;
      sel_nxt      = sel;
      last_ptr_nxt = last_ptr;
      beat_cnt_nxt = beat_cnt;
      cap          = 1'b0;
      burst_end    = 1'b0;
      ack          = 8'h00;
      busy         = (state == XFER);
      can_cap      = !out_valid || out_ready;
      pick_idle    = rr_pick(req, last_ptr);
      // The current owner is masked out so it drops to lowest priority at burst end.
      pick_rearb   = rr_pick(req & ~gnt, sel);

      case (state)
         IDLE: begin
            if (pick_idle[3]) begin
               gnt_nxt      = 8'b0000_0001 << pick_idle[2:0];
               sel_nxt      = pick_idle[2:0];
               beat_cnt_nxt = 5'd0;
               state_nxt    = XFER;
            end
         end
         XFER: begin
            if (!req[sel]) begin
               last_ptr_nxt = sel;
               gnt_nxt      = 8'h00;
               beat_cnt_nxt = 5'd0;
               state_nxt    = IDLE;
            end else if (can_cap) begin
               cap          = 1'b1;
               ack          = gnt;
               beat_cnt_nxt = beat_cnt + 5'd1;
               burst_end    = req_last[sel] || (beat_cnt + 5'd1 == 5'(MAX_BURST));
               if (burst_end) begin
                  last_ptr_nxt = sel;
                  beat_cnt_nxt = 5'd0;
                  if (pick_rearb[3]) begin
                     gnt_nxt = 8'b0000_0001 << pick_rearb[2:0];
                     sel_nxt = pick_rearb[2:0];
                  end else begin
                     gnt_nxt   = 8'h00;
                     state_nxt = IDLE;
                  end
               end
            end
         end
         default: begin
            gnt_nxt   = 8'h00;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         gnt      <= 8'h00;
         sel      <= 3'd0;
         last_ptr <= 3'd7;
         beat_cnt <= 5'd0;
      end else begin
         state    <= state_nxt;
         gnt      <= gnt_nxt;
         sel      <= sel_nxt;
         last_ptr <= last_ptr_nxt;
         beat_cnt <= beat_cnt_nxt;
      end
   end

   // A capture in the same cycle as an accept keeps out_valid high: one beat per cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else if (cap) begin
         out_data  <= mux_result;
         out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   a_gnt_onehot : assert property (@(posedge clk) disable iff (!reset_n) $onehot0(gnt));
   a_sel_match  : assert property (@(posedge clk) disable iff (!reset_n) (gnt != 8'h00) |-> gnt[sel]);

endmodule
